// File: rtl/audio_lpr_fir.sv
// Decimating FIR low-pass filter that turns the demodulated baseband stream into
// mono (L+R) audio. It runs one MAC per clock and produces one output per DECIM input samples.
module audio_lpr_fir #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_TAPS   = 32,
   parameter int DECIM      = 8,
   parameter int BITS       = 10,
   parameter logic signed [DATA_WIDTH-1:0] COEFFS [NUM_TAPS] = '{
      -1, -3, -5, -6, -4,  2, 12, 25, 40, 56, 70, 82, 90, 95, 98, 99,
      99, 98, 95, 90, 82, 70, 56, 40, 25, 12,  2, -4, -6, -5, -3, -1}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_dout,
   input  logic                  in_empty,
   output logic                  in_rd_en,
   input  logic                  out_full,
   output logic                  out_wr_en,
   output logic [DATA_WIDTH-1:0] out_din
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int KW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam logic [PW-1:0] LAST_PH  = PW'(DECIM - 1);
   localparam logic [KW-1:0] LAST_TAP = KW'(NUM_TAPS - 1);

   typedef enum logic [1:0] {FILL, MAC, OUT} state_t;

   state_t                       state_q, state_d;
   logic [PW-1:0]                phase_q, phase_d;
   logic [KW-1:0]                tap_q, tap_d;
   logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
   logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
   logic signed [DATA_WIDTH-1:0] hist_q [NUM_TAPS];

   logic                           pop, push;
   logic signed [2*DATA_WIDTH-1:0] coef_x, samp_x, prod;
   logic signed [DATA_WIDTH-1:0]   term;

   // Scale the full-width product back to sample precision; truncation, no saturation.
   function automatic logic signed [DATA_WIDTH-1:0] dequant(
      input logic signed [2*DATA_WIDTH-1:0] p);
      logic signed [2*DATA_WIDTH-1:0] s;
      s = p >>> BITS;
      return s[DATA_WIDTH-1:0];
   endfunction

   assign coef_x = {{DATA_WIDTH{COEFFS[tap_q][DATA_WIDTH-1]}}, COEFFS[tap_q]};
   assign samp_x = {{DATA_WIDTH{hist_q[tap_q][DATA_WIDTH-1]}}, hist_q[tap_q]};
   assign prod   = coef_x * samp_x;
   assign term   = dequant(prod);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      tap_d   = tap_q;
      acc_d   = acc_q;
      dout_d  = dout_q;
      pop     = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         FILL: begin
            pop = ~in_empty;
            if (pop) begin
               if (phase_q == LAST_PH) begin
                  phase_d = '0;
                  acc_d   = '0;
                  tap_d   = '0;
                  state_d = MAC;
               end else begin
                  phase_d = phase_q + PW'(1);
               end
            end
         end
         MAC: begin
            acc_d = acc_q + term;
            tap_d = tap_q + KW'(1);
            if (tap_q == LAST_TAP) begin
               dout_d  = acc_d;
               tap_d   = '0;
               state_d = OUT;
            end
         end
         OUT: begin
            push = ~out_full;
            if (push) state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   // Strobes are qualified by reset so both read 0 for as long as reset is held low.
   assign in_rd_en  = reset & pop;
   assign out_wr_en = reset & push;
   assign out_din   = dout_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FILL;
         phase_q <= '0;
         tap_q   <= '0;
         acc_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         tap_q   <= tap_d;
         acc_q   <= acc_d;
         dout_q  <= dout_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_TAPS; i++) hist_q[i] <= '0;
      end else if (pop) begin
         hist_q[0] <= in_dout;
         for (int i = 1; i < NUM_TAPS; i++) hist_q[i] <= hist_q[i-1];
      end
   end

endmodule

// File: tb/tb_audio_lpr_fir.sv
// Testbench for audio_lpr_fir. A golden model fills a scoreboard queue and a vector
// table drives the scenarios; hand-written sequences cover backpressure and reset during MAC.
module tb_audio_lpr_fir;
   localparam int NT = 32, DEC = 8, BITS = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_dout;
   logic        in_empty, in_rd_en, out_full, out_wr_en;
   logic [31:0] out_din;

   always #5 clk = ~clk;

   audio_lpr_fir dut (
      .clk(clk), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
      .in_rd_en(in_rd_en), .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din));

   int H [NT] = '{
      -1, -3, -5, -6, -4,  2, 12, 25, 40, 56, 70, 82, 90, 95, 98, 99,
      99, 98, 95, 90, 82, 70, 56, 40, 25, 12,  2, -4, -6, -5, -3, -1};

   int  checks = 0, errors = 0;
   int  xh [NT];
   int  phase_m = 0;
   int  exp_q[$], got[$], ref_q[$];
   time pop_t[$], wr_t[$];

   typedef struct {
      int               kind;   // 0 impulse, 1 dc 1024, 2 ramp, 3 full-scale
      int               nsamp;
      bit               gaps;
      int               nexp;
      logic [4:0][31:0] exp_v;
   } vec_t;
   vec_t vt [5];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < NT; k++) xh[k] = 0;
      phase_m = 0;
      exp_q.delete(); got.delete(); pop_t.delete(); wr_t.delete();
   endtask

   task automatic model_accept(input int v);
      int     acc;
      longint p;
      for (int k = NT - 1; k > 0; k--) xh[k] = xh[k-1];
      xh[0] = v;
      phase_m++;
      if (phase_m == DEC) begin
         phase_m = 0;
         acc = 0;
         for (int k = 0; k < NT; k++) begin
            p = longint'(H[k]) * longint'(xh[k]);
            acc += int'(p >>> BITS);
         end
         exp_q.push_back(acc);
         pop_t.push_back($time);
      end
   endtask

   function automatic int sample_of(input int kind, input int i);
      case (kind)
         0:       return (i == 0) ? 1024 : 0;
         1:       return 1024;
         2:       return i * 1024;
         default: return 32'h7FFF_FFFF;
      endcase
   endfunction

   // Output monitor: samples one time unit before each rising edge.
   always begin
      @(negedge clk);
      #4;
      if (reset === 1'b1 && out_wr_en === 1'b1) begin
         got.push_back(int'(out_din));
         wr_t.push_back($time + 1);
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write actual=%0d required=no_write", int'(out_din));
         end else begin
            check("scoreboard", int'(out_din), exp_q.pop_front());
         end
      end
   end

   // Called on a falling edge; returns on a falling edge after the sample was popped.
   task automatic push_sample(input int v, input bit gaps);
      int g;
      if (gaps) begin
         g = 0;
         while ($urandom_range(1, 0) == 1 && g < 16) begin
            in_empty = 1'b1;
            @(negedge clk);
            g++;
         end
      end
      in_dout  = v;
      in_empty = 1'b0;
      #1;
      g = 0;
      while (in_rd_en !== 1'b1 && g < 400) begin
         @(negedge clk); #1; g++;
      end
      if (in_rd_en !== 1'b1) begin
         checks++; errors++;
         $display("FAIL pop_timeout actual=%0b required=1", in_rd_en);
         @(negedge clk);
         return;
      end
      @(posedge clk);
      model_accept(v);
      @(negedge clk);
      in_empty = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; in_empty = 1'b1; out_full = 1'b0;
      repeat (3) @(negedge clk);
      model_clear();
      reset = 1'b1;
   endtask

   task automatic drain(input int n);
      int g = 0;
      while (got.size() < n && g < 300) begin
         @(negedge clk); g++;
      end
      check("drain_count", got.size(), n);
      check("drain_leftover", exp_q.size(), 0);
   endtask

   initial begin
      int s7, s15, s23, stot;
      s7 = 0; s15 = 0; s23 = 0; stot = 0;
      for (int k = 0; k < NT; k++) begin
         if (k <= 7)  s7  += H[k];
         if (k <= 15) s15 += H[k];
         if (k <= 23) s23 += H[k];
         stot += H[k];
      end
      vt[0] = '{kind: 0, nsamp: 40,  gaps: 1'b0, nexp: 5, exp_v: '0};
      vt[0].exp_v[0] = H[7]; vt[0].exp_v[1] = H[15]; vt[0].exp_v[2] = H[23];
      vt[0].exp_v[3] = H[31]; vt[0].exp_v[4] = 0;
      vt[1] = '{kind: 1, nsamp: 64,  gaps: 1'b0, nexp: 5, exp_v: '0};
      vt[1].exp_v[0] = s7; vt[1].exp_v[1] = s15; vt[1].exp_v[2] = s23;
      vt[1].exp_v[3] = stot; vt[1].exp_v[4] = stot;
      vt[2] = '{kind: 2, nsamp: 256, gaps: 1'b0, nexp: 0, exp_v: '0};
      vt[3] = '{kind: 2, nsamp: 256, gaps: 1'b1, nexp: 0, exp_v: '0};
      vt[4] = '{kind: 3, nsamp: 64,  gaps: 1'b0, nexp: 0, exp_v: '0};

      reset = 1'b0; in_empty = 1'b0; in_dout = 32'h1234; out_full = 1'b0;
      model_clear();
      #12;
      check("reset_rd_en", int'(in_rd_en), 0);
      check("reset_wr_en", int'(out_wr_en), 0);
      check("reset_out_din", int'(out_din), 0);

      for (int v = 0; v < 5; v++) begin
         do_reset();
         for (int i = 0; i < vt[v].nsamp; i++) push_sample(sample_of(vt[v].kind, i), vt[v].gaps);
         in_empty = 1'b1;
         drain(vt[v].nsamp / DEC);
         for (int j = 0; j < vt[v].nexp; j++)
            if (j < got.size()) check($sformatf("vec%0d_out%0d", v, j), got[j], int'(vt[v].exp_v[j]));
         if (vt[v].kind == 0)
            for (int j = 0; j < 5; j++)
               if (j < wr_t.size() && j < pop_t.size())
                  check($sformatf("impulse_latency%0d", j), int'((wr_t[j] - pop_t[j]) / 10), 33);
         if (v == 2) ref_q = got;
         if (v == 3) begin
            check("gap_count", got.size(), ref_q.size());
            for (int j = 0; j < got.size() && j < ref_q.size(); j++)
               check($sformatf("gap_out%0d", j), got[j], ref_q[j]);
         end
      end

      // Backpressure: result held in OUT with a sample waiting upstream.
      do_reset();
      out_full = 1'b1;
      for (int i = 0; i < DEC; i++) push_sample(1024, 1'b0);
      in_dout = 1024; in_empty = 1'b0;
      repeat (36) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         #1;
         check("bp_wr_en", int'(out_wr_en), 0);
         check("bp_rd_en", int'(in_rd_en), 0);
         check("bp_out_din", int'(out_din), s7);
         @(negedge clk);
      end
      check("bp_no_write", got.size(), 0);
      out_full = 1'b0; in_empty = 1'b1;
      #1;
      check("bp_release_wr", int'(out_wr_en), 1);
      @(negedge clk); #1;
      check("bp_single_wr", int'(out_wr_en), 0);
      check("bp_write_count", got.size(), 1);

      // Reset asserted part-way through the second MAC pass.
      do_reset();
      for (int i = 0; i < 2 * DEC; i++) push_sample(i * 1024, 1'b0);
      repeat (10) @(negedge clk);
      check("mid_first_out", got.size(), 1);
      in_dout = 5; in_empty = 1'b0; out_full = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("mid_rd_en", int'(in_rd_en), 0);
      check("mid_wr_en", int'(out_wr_en), 0);
      check("mid_out_din", int'(out_din), 0);
      repeat (2) @(negedge clk);
      model_clear();
      in_empty = 1'b1;
      reset = 1'b1;
      for (int i = 0; i < 40; i++) push_sample(sample_of(0, i), 1'b0);
      in_empty = 1'b1;
      drain(5);
      for (int j = 0; j < 5 && j < got.size(); j++)
         check($sformatf("post_reset_out%0d", j), got[j], int'(vt[0].exp_v[j]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
